// File: rtl/nios2_qsys_cpu_mult_unit.sv
// Pipelined multiplier for the Nios II custom-instruction datapath.
// Stage 1 registers four half-width partial products plus a sign-correction
// word; the remaining stages sum them and delay the selected word so that
// done appears exactly PIPE_STAGES cycles after an accepted start.
module nios2_qsys_cpu_mult_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_mul_src1,
  input  logic [DATA_W-1:0] A_mul_src2,
  input  logic [1:0]        A_mul_op,
  input  logic              A_mul_start,
  input  logic              A_mul_stall,
  input  logic              A_mul_flush,
  output logic              A_mul_done,
  output logic [DATA_W-1:0] A_mul_result,
  output logic              A_mul_busy
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mul_op_e;

  logic                   w_accept;
  logic [HALF_W-1:0]      w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  logic                   w_a_neg, w_b_neg;
  logic [DATA_W-1:0]      w_corr;
  logic [PIPE_STAGES-1:0] r_v, w_v_next;

  logic [DATA_W-1:0]      r_pp_ll, r_pp_hl, r_pp_lh, r_pp_hh, r_corr;
  mul_op_e                r_op;

  logic [PROD_W-1:0]      w_prod;
  logic [DATA_W-1:0]      w_word, w_final, r_result;
  logic                   w_done;

  assign w_accept = A_mul_start & ~A_mul_stall & ~A_mul_flush;
  assign w_a_lo   = A_mul_src1[HALF_W-1:0];
  assign w_a_hi   = A_mul_src1[DATA_W-1:HALF_W];
  assign w_b_lo   = A_mul_src2[HALF_W-1:0];
  assign w_b_hi   = A_mul_src2[DATA_W-1:HALF_W];

  // Signed operands are treated as unsigned plus a high-word correction:
  // a_s*b_s = a_u*b_u - a_neg*b_u*2^W - b_neg*a_u*2^W (mod 2^2W).
  always_comb begin
    w_a_neg = (A_mul_op == OP_MULXSU || A_mul_op == OP_MULXSS) && A_mul_src1[DATA_W-1];
    w_b_neg = (A_mul_op == OP_MULXSS) && A_mul_src2[DATA_W-1];
    w_corr  = '0 - (w_a_neg ? A_mul_src2 : '0) - (w_b_neg ? A_mul_src1 : '0);
  end

  // Valid shift chain: flush beats stall, stall freezes every stage.
  always_comb begin
    w_v_next = r_v;
    if (A_mul_flush) begin
      w_v_next = '0;
    end else if (!A_mul_stall) begin
      w_v_next[0] = w_accept;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        w_v_next[i] = r_v[i-1];
      end
    end
  end

  // Valid bit register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_v <= '0;
    else          r_v <= w_v_next;
  end

  // Stage 1: operands are sampled only on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pp_ll <= '0;
      r_pp_hl <= '0;
      r_pp_lh <= '0;
      r_pp_hh <= '0;
      r_corr  <= '0;
      r_op    <= OP_MUL;
    end else if (w_accept) begin
      r_pp_ll <= DATA_W'(w_a_lo) * DATA_W'(w_b_lo);
      r_pp_hl <= DATA_W'(w_a_hi) * DATA_W'(w_b_lo);
      r_pp_lh <= DATA_W'(w_a_lo) * DATA_W'(w_b_hi);
      r_pp_hh <= DATA_W'(w_a_hi) * DATA_W'(w_b_hi);
      r_corr  <= w_corr;
      r_op    <= mul_op_e'(A_mul_op);
    end
  end

  // Partial-product summation and word selection.
  always_comb begin
    w_prod = PROD_W'(r_pp_ll)
           + (PROD_W'(r_pp_hl) << HALF_W)
           + (PROD_W'(r_pp_lh) << HALF_W)
           + {r_pp_hh, {DATA_W{1'b0}}}
           + {r_corr,  {DATA_W{1'b0}}};
    w_word = (r_op == OP_MUL) ? w_prod[DATA_W-1:0] : w_prod[PROD_W-1:DATA_W];
  end

  if (PIPE_STAGES == 1) begin : g_comb_sum
    assign w_final = w_word;
  end else begin : g_reg_sum
    logic [DATA_W-1:0] r_word [1:PIPE_STAGES-1];

    // Sum register followed by pure delay stages up to the output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 1; i < PIPE_STAGES; i++) r_word[i] <= '0;
      end else if (!A_mul_stall && !A_mul_flush) begin
        if (r_v[0]) r_word[1] <= w_word;
        for (int unsigned i = 2; i < PIPE_STAGES; i++) begin
          if (r_v[i-1]) r_word[i] <= r_word[i-1];
        end
      end
    end

    assign w_final = r_word[PIPE_STAGES-1];
  end

  assign w_done = r_v[PIPE_STAGES-1] & ~A_mul_stall & ~A_mul_flush;

  // Holding register keeps the last delivered word visible while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_result <= '0;
    else if (w_done) r_result <= w_final;
  end

  assign A_mul_done   = w_done;
  assign A_mul_result = w_done ? w_final : r_result;
  assign A_mul_busy   = |r_v;

endmodule

// File: doc/nios2_qsys_cpu_mult_unit.md
NIOS2_QSYS_CPU_MULT_UNIT -- requirements
Module: nios2_qsys_cpu_mult_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand width; SHALL be even, 16..64.
REQ-002 Parameter PIPE_STAGES, default 2, start-to-done latency in cycles; SHALL be 1..4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 A_mul_src1  input  DATA_W  operand A.
REQ-006 A_mul_src2  input  DATA_W  operand B.
REQ-007 A_mul_op  input  2  00 MUL low word; 01 MULXUU high word; 10 MULXSU high word (A signed, B unsigned); 11 MULXSS high word (both signed).
REQ-008 A_mul_start  input  1  launches one operation with current src1/src2/op.
REQ-009 A_mul_stall  input  1  freezes the whole pipeline.
REQ-010 A_mul_flush  input  1  kills all in-flight operations.
REQ-011 A_mul_done  output  1  A_mul_result is valid this cycle.
REQ-012 A_mul_result  output  DATA_W  selected product word.
REQ-013 A_mul_busy  output  1  at least one operation in flight and not yet completed.

Function
REQ-014 Full product P SHALL equal (A extended per op) x (B extended per op) over 2*DATA_W bits; sign extension applies only to operands marked signed by A_mul_op.
REQ-015 Op 00 SHALL return P[DATA_W-1:0], identical for signed/unsigned inputs; ops 01/10/11 SHALL return P[2*DATA_W-1:DATA_W].
REQ-016 Stage 1 SHALL form four unsigned (DATA_W/2)x(DATA_W/2) partial products (lo*lo, hi*lo, lo*hi, hi*hi) plus registered sign-correction terms; later stages SHALL sum them; no single multiply wider than DATA_W/2 x DATA_W/2.
REQ-017 With PIPE_STAGES=1, products are registered once and summation is combinational to the output.
REQ-018 Each stage SHALL carry a valid bit and the op code; valid enters stage 1 when A_mul_start=1, A_mul_stall=0, A_mul_flush=0.
REQ-019 A start sampled at edge N with no stall SHALL produce A_mul_done=1 in the cycle after edge N+PIPE_STAGES-1 (exactly PIPE_STAGES cycles later).
REQ-020 Throughput SHALL be one operation per cycle; back-to-back starts SHALL complete on consecutive cycles in issue order.
REQ-021 While A_mul_stall=1: all stage registers and valid bits hold, A_mul_start ignored, A_mul_done forced 0, A_mul_result holds last value.
REQ-022 A_mul_flush=1 SHALL clear every valid bit at the next edge; flush has priority over stall and start; A_mul_done SHALL be 0 in the flush cycle.
REQ-023 A_mul_done = last-stage valid AND NOT stall AND NOT flush; A_mul_result SHALL be unchanged whenever A_mul_done=0 and no new result arrives.
REQ-024 A_mul_busy SHALL be OR of all stage valid bits.
REQ-025 Operands SHALL be sampled only at the start edge; later input changes SHALL not affect that operation.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all valid bits, data registers and A_mul_result to 0; A_mul_done=0, A_mul_busy=0.
REQ-027 Reset asserted mid-operation SHALL discard in-flight operations; no done SHALL appear after release without a new start.
REQ-028 First start SHALL be accepted at the first rising edge with reset_n=1.

Verification (DATA_W=32, PIPE_STAGES=2 unless stated)
REQ-029 Start op 00, src1=0x0001_0003, src2=0x0002_0005 -> done 2 cycles later, result 0x000B_000F.
REQ-030 Op 11 src1=src2=0xFFFF_FFFF -> result 0x0000_0000; op 01 same operands -> 0xFFFF_FFFE; op 10 src1=0xFFFF_FFFF, src2=0x0000_0002 -> 0xFFFF_FFFF.
REQ-031 Four back-to-back starts (2*3, 7*9, 0x10000*0x10000 op01, 0x8000_0000*2 op11) -> done on 4 consecutive cycles: 6, 63, 0x1, 0xFFFF_FFFF.
REQ-032 Start, then stall held 3 cycles after first edge -> done suppressed during stall, asserted one cycle after stall drops, result correct; busy=1 throughout.
REQ-033 Start twice, flush next cycle (with stall=1 and start=1) -> no done ever, busy=0 after flush edge; reset_n pulse mid-operation -> same outcome, result 0.
REQ-034 Random signed/unsigned sweep, DATA_W in {16,32,64}, PIPE_STAGES in {1,2,4}, random stall/flush -> every done matches reference model in order, latency exact.
